// File: rtl/rgb_pkg.sv
// Shared opcodes, header field positions and the per-channel write command
// for the RGB PWM controller.
package rgb_pkg;

    localparam logic [1:0] OP_SET    = 2'b00;
    localparam logic [1:0] OP_FADE   = 2'b01;
    localparam logic [1:0] OP_ALLOFF = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    localparam int HDR_BIT = 7;
    localparam int OP_HI   = 6;
    localparam int OP_LO   = 5;
    localparam int CH_HI   = 4;
    localparam int CH_LO   = 0;

    typedef enum logic {
        S_IDLE,
        S_WAIT_DATA
    } state_t;

    // One-cycle write strobes into a channel; data is shared by all channels.
    typedef struct packed {
        logic       clr;
        logic       set;
        logic       fade;
        logic [7:0] data;
    } chan_cmd_t;

endpackage

// File: rtl/pwm_channel.sv
// One LED channel: duty/target with fade stepping, period-aligned shadow
// of the duty, and the registered PWM comparator.
module pwm_channel
    import rgb_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  chan_cmd_t           cmd,
    input  logic                fade_tick,
    input  logic                pwm_wrap,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] duty_cur,
    output logic                led
);

    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] active;
    logic [PWM_BITS-1:0] wdata;

    assign wdata = PWM_BITS'(cmd.data);

    // Explicit writes take priority over the fade step landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_cur <= '0;
            target   <= '0;
        end else if (cmd.clr) begin
            duty_cur <= '0;
            target   <= '0;
        end else if (cmd.set) begin
            duty_cur <= wdata;
            target   <= wdata;
        end else begin
            if (cmd.fade)
                target <= wdata;
            if (fade_tick && duty_cur != target)
                duty_cur <= (duty_cur < target) ? duty_cur + 1'b1 : duty_cur - 1'b1;
        end
    end

    // Shadow only reloads at the period boundary so a pulse is never cut short.
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= '0;
            led    <= 1'b0;
        end else begin
            if (pwm_wrap)
                active <= duty_cur;
            led <= (pwm_cnt < active);
        end
    end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Framed byte-command parser driving CHANNELS PWM outputs with shared
// PWM/fade prescalers and a per-channel fade engine.
module rgb_pwm_ctrl
    import rgb_pkg::*;
#(
    parameter int CHANNELS       = 3,
    parameter int PWM_BITS       = 8,
    parameter int PWM_DIV        = 4,
    parameter int FADE_DIV       = 100000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [CHANNELS-1:0] led,
    output logic                cmd_ack,
    output logic                frame_err
);

    localparam int PW = (PWM_DIV > 1)        ? $clog2(PWM_DIV)        : 1;
    localparam int FW = (FADE_DIV > 1)       ? $clog2(FADE_DIV)       : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        state_q, state_d;
    logic [1:0]    op_q;
    logic [4:0]    ch_q;
    logic [TW-1:0] to_q;
    logic          timeout;

    logic          hdr;
    logic [1:0]    op_in;
    logic          ch_ok;
    logic          ack_d, err_d, all_clr, set_wr, fade_wr;

    logic [PW-1:0]       pdiv_q;
    logic [FW-1:0]       fdiv_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_tick, fade_tick, pwm_wrap;

    logic [CHANNELS-1:0][PWM_BITS-1:0] duty_cur;
    chan_cmd_t                         cmd [CHANNELS];

    assign hdr     = rx_data[HDR_BIT];
    assign op_in   = rx_data[OP_HI:OP_LO];
    assign ch_ok   = 32'(ch_q) < CHANNELS;
    assign timeout = (state_q == S_WAIT_DATA) && (to_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:
                if (rx_valid && hdr && (op_in == OP_SET || op_in == OP_FADE))
                    state_d = S_WAIT_DATA;
            S_WAIT_DATA:
                if (rx_valid || timeout)
                    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Exactly one of ack/err can be raised per accepted byte or timeout.
    always_comb begin
        ack_d   = 1'b0;
        err_d   = 1'b0;
        all_clr = 1'b0;
        set_wr  = 1'b0;
        fade_wr = 1'b0;
        case (state_q)
            S_IDLE:
                if (rx_valid) begin
                    if (!hdr)
                        err_d = 1'b1;
                    else if (op_in == OP_ALLOFF) begin
                        all_clr = 1'b1;
                        ack_d   = 1'b1;
                    end else if (op_in == OP_RSVD)
                        err_d = 1'b1;
                end
            S_WAIT_DATA:
                if (rx_valid) begin
                    if (ch_ok) begin
                        ack_d   = 1'b1;
                        set_wr  = (op_q == OP_SET);
                        fade_wr = (op_q == OP_FADE);
                    end else
                        err_d = 1'b1;
                end else if (timeout)
                    err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_SET;
            ch_q      <= '0;
            to_q      <= '0;
            cmd_ack   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (state_q == S_IDLE && rx_valid && hdr) begin
                op_q <= op_in;
                ch_q <= rx_data[CH_HI:CH_LO];
            end
            to_q      <= (state_q == S_IDLE) ? '0 : to_q + 1'b1;
            cmd_ack   <= ack_d;
            frame_err <= err_d;
        end
    end

    assign pwm_tick  = (pdiv_q == PW'(PWM_DIV - 1));
    assign fade_tick = (fdiv_q == FW'(FADE_DIV - 1));
    assign pwm_wrap  = pwm_tick && (pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pdiv_q  <= '0;
            fdiv_q  <= '0;
            pwm_cnt <= '0;
        end else begin
            pdiv_q <= pwm_tick  ? '0 : pdiv_q + 1'b1;
            fdiv_q <= fade_tick ? '0 : fdiv_q + 1'b1;
            if (pwm_tick)
                pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign cmd[i].clr  = all_clr;
        assign cmd[i].set  = set_wr  && (ch_q == 5'(i));
        assign cmd[i].fade = fade_wr && (ch_q == 5'(i));
        assign cmd[i].data = rx_data;

        pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .cmd       (cmd[i]),
            .fade_tick (fade_tick),
            .pwm_wrap  (pwm_wrap),
            .pwm_cnt   (pwm_cnt),
            .duty_cur  (duty_cur[i]),
            .led       (led[i])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed bench for rgb_pwm_ctrl: framing, SET/FADE/ALLOFF, errors,
// timeout, reset mid-frame and measured LED duty per period.
module tb_rgb_pwm_ctrl;

    localparam int CH = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic [CH-1:0] led;
    logic          cmd_ack, frame_err;

    int n_assert = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    rgb_pwm_ctrl #(
        .CHANNELS(CH), .PWM_BITS(8), .PWM_DIV(1), .FADE_DIV(10), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .led(led), .cmd_ack(cmd_ack), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (cmd_ack)              ack_cnt++;
        if (frame_err)            err_cnt++;
        if (cmd_ack && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // With PWM_DIV=1 any 256 consecutive cycles cover exactly one period.
    task automatic measure(output int h0, output int h1, output int h2);
        h0 = 0; h1 = 0; h2 = 0;
        repeat (256) begin
            @(negedge clk);
            h0 += int'(led[0]);
            h1 += int'(led[1]);
            h2 += int'(led[2]);
        end
    endtask

    initial begin
        int a0, e0, h0, h1, h2, prev, mono, waited;

        cycles(3);
        check("reset_led", int'(led), 0);
        check("reset_ack", int'(cmd_ack), 0);
        check("reset_err", int'(frame_err), 0);
        check("reset_duty", int'(dut.duty_cur), 0);
        rst = 1'b0;
        cycles(2);

        // SET ch0 = 255
        a0 = ack_cnt; e0 = err_cnt;
        send(8'h80); send(8'hFF);
        check("set_ack", ack_cnt - a0, 1);
        check("set_no_err", err_cnt - e0, 0);
        check("set_duty0", int'(dut.duty_cur[0]), 255);
        cycles(300);
        measure(h0, h1, h2);
        check("set_led0_high", h0, 255);
        check("set_led1_dark", h1, 0);
        check("set_led2_dark", h2, 0);

        // FADE ch1 to 16
        a0 = ack_cnt;
        send(8'hA1); send(8'h10);
        check("fade_ack", ack_cnt - a0, 1);
        check("fade_not_immediate", int'(dut.duty_cur[1] < 8'd2), 1);
        prev = 0; mono = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (int'(dut.duty_cur[1]) < prev) mono = 0;
            prev = int'(dut.duty_cur[1]);
            if (i == 100) check("fade_midway", int'(dut.duty_cur[1] < 8'd16), 1);
        end
        check("fade_monotonic", mono, 1);
        check("fade_reached", int'(dut.duty_cur[1]), 16);
        check("fade_ch0_kept", int'(dut.duty_cur[0]), 255);
        cycles(300);
        measure(h0, h1, h2);
        check("fade_led1_duty", h1, 16);

        // ALLOFF during a fade
        send(8'h82); send(8'd200);
        check("set2_duty", int'(dut.duty_cur[2]), 200);
        send(8'hA0); send(8'h00);
        cycles(30);
        check("fade0_started", int'(dut.duty_cur[0] < 8'd255), 1);
        a0 = ack_cnt; e0 = err_cnt;
        send(8'hC0);
        check("alloff_ack", ack_cnt - a0, 1);
        check("alloff_no_err", err_cnt - e0, 0);
        check("alloff_duty", int'(dut.duty_cur), 0);
        cycles(50);
        check("alloff_target_zero", int'(dut.duty_cur), 0);
        cycles(300);
        measure(h0, h1, h2);
        check("alloff_leds", h0 + h1 + h2, 0);

        // Bad channel, including the first out-of-range index
        send(8'h80); send(8'h30);
        a0 = ack_cnt; e0 = err_cnt;
        send(8'h85); send(8'h40);
        check("badch5_err", err_cnt - e0, 1);
        check("badch5_no_ack", ack_cnt - a0, 0);
        send(8'h83); send(8'h40);
        check("badch3_err", err_cnt - e0, 2);
        check("badch_no_ack", ack_cnt - a0, 0);
        check("badch_duty0", int'(dut.duty_cur[0]), 8'h30);
        check("badch_duty12", int'(dut.duty_cur[1]) + int'(dut.duty_cur[2]), 0);

        // Reserved opcode and non-header byte in IDLE
        e0 = err_cnt; a0 = ack_cnt;
        send(8'hE0);
        check("rsvd_err", err_cnt - e0, 1);
        send(8'h55);
        check("nonhdr_err", err_cnt - e0, 2);
        check("rsvd_no_ack", ack_cnt - a0, 0);

        // Header timeout
        e0 = err_cnt; a0 = ack_cnt;
        send(8'h80);
        waited = 0;
        while (err_cnt == e0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("timeout_seen", int'(err_cnt != e0), 1);
        check("timeout_window", int'(waited >= 45 && waited <= 56), 1);
        check("timeout_no_ack", ack_cnt - a0, 0);
        check("timeout_duty0", int'(dut.duty_cur[0]), 8'h30);
        e0 = err_cnt;
        send(8'h33);
        check("after_timeout_err", err_cnt - e0, 1);
        check("after_timeout_duty0", int'(dut.duty_cur[0]), 8'h30);

        // Reset mid-frame
        send(8'h80);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst_duty", int'(dut.duty_cur), 0);
        check("rst_led", int'(led), 0);
        e0 = err_cnt; a0 = ack_cnt;
        send(8'h20);
        check("rst_frame_err", err_cnt - e0, 1);
        check("rst_frame_no_ack", ack_cnt - a0, 0);
        check("rst_frame_duty", int'(dut.duty_cur), 0);
        measure(h0, h1, h2);
        check("rst_frame_leds", h0 + h1 + h2, 0);

        check("ack_err_exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_ctrl.md
Name: rgb_pwm_ctrl

Overview:
Parametrised multi-channel LED PWM controller with a framed byte-command parser and per-channel hardware fading.
Consumes the byte/valid stream from the UART receiver and drives CHANNELS LED outputs at PWM_BITS resolution.
Replaces the fixed 3-LED, single-byte PWM path.

Parameters:
CHANNELS, 3, number of PWM outputs (1..32)
PWM_BITS, 8, duty and PWM counter width (fixed at 8 by protocol, kept for reuse)
PWM_DIV, 4, clk cycles per PWM counter step (>=1)
FADE_DIV, 100000, clk cycles per fade step (>=1)
TIMEOUT_CYCLES, 1000000, maximum gap between header and data byte

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data valid in that cycle
led  out  CHANNELS  PWM outputs, bit i = channel i
cmd_ack  out  1  one-cycle pulse when a frame is executed
frame_err  out  1  one-cycle pulse on a rejected or timed-out frame

Behaviour:
- Reset: led=0, cmd_ack=0, frame_err=0, all duty/target/active registers=0, parser IDLE, counters=0.
- Header byte: bit7=1; bits[6:5]=opcode; bits[4:0]=channel.
- Opcodes: 00 SET (immediate duty); 01 FADE (target duty); 10 ALLOFF (single byte); 11 reserved.
- Parser FSM states IDLE, WAIT_DATA:
  - IDLE, rx_valid, bit7=0: byte dropped, frame_err pulse.
  - IDLE, header, opcode 10: in the next cycle, every duty_cur and target is set to 0 and cmd_ack pulses; stay IDLE.
  - IDLE, header, opcode 11: frame_err pulse; stay IDLE.
  - IDLE, header, opcode 00/01: latch opcode and channel; go to WAIT_DATA; clear the timeout counter.
  - WAIT_DATA, rx_valid: any byte value is data.
    - Channel < CHANNELS, SET: duty_cur[ch]=target[ch]=data.
    - Channel < CHANNELS, FADE: target[ch]=data.
    - Either case: cmd_ack pulses 1 cycle after the data strobe.
    - Channel >= CHANNELS: frame_err pulse instead, no register change.
    - Always return to IDLE.
  - WAIT_DATA, no byte for TIMEOUT_CYCLES: frame_err pulse; return to IDLE.
- Fade:
  - Shared prescaler produces fade_tick every FADE_DIV cycles.
  - On fade_tick, each channel with duty_cur != target moves duty_cur one step (+1 or -1) toward target.
  - A SET or ALLOFF write to a channel in the same cycle as fade_tick overrides the fade step.
- PWM:
  - Shared prescaler produces pwm_tick every PWM_DIV cycles.
  - PWM counter (PWM_BITS) increments on pwm_tick and wraps 255->0.
  - Period = 256*PWM_DIV clk cycles.
  - On pwm_tick with counter wrapping to 0, active[i] is loaded from duty_cur[i]. Duty changes therefore take effect only at period boundaries (glitch-free).
  - led[i] is registered: led[i] = (counter < active[i]).
  - Duty 0 gives constant low. Duty 255 gives high for 255/256 of the period.
- Latency:
  - Data strobe to register update: 1 cycle.
  - Register update to led change: up to one PWM period + 1 cycle.
- Reset mid-frame: parser returns to IDLE and the partial frame is discarded.
- Reset mid-fade: duty and target return to 0, so LEDs go dark.
- cmd_ack and frame_err never assert in the same cycle.

Decomposition:
- Package rgb_pkg holds:
  - opcode constants OP_SET, OP_FADE, OP_ALLOFF, OP_RSVD
  - HDR_BIT=7
  - header field bit positions
- One sub-module, pwm_channel, instanced via generate per channel. It contains the fade stepper, active shadow register and comparator.
- rgb_pwm_ctrl holds the parser FSM and the shared prescalers/counter.

Test Plan:
- Set full brightness: bytes 0x80, 0xFF (SET ch0=255) -> cmd_ack once; after the next wrap, led[0] is high 255 of every 256 PWM steps; led[1], led[2] stay 0.
- Fade up: 0xA1, 0x10 (FADE ch1 to 16) with FADE_DIV=10 -> duty_cur[1] reaches 16 after 160 cycles, monotonic; led[1] duty tracks it at period boundaries.
- All off during a fade: SET ch2=200 then ALLOFF 0xC0 -> all duty and target are 0 next cycle; led all low from the next period.
- Bad channel: 0x85, 0x40 with CHANNELS=3 -> frame_err 1 pulse; no cmd_ack; duties unchanged.
- Header timeout: 0x80, then idle TIMEOUT_CYCLES=50 -> frame_err at cycle 50. A following 0x33 counts as a non-header and produces another frame_err.
- Reset mid-frame: 0x80, rst for 1 cycle, then 0x20 -> the 0x20 is treated in IDLE (frame_err); no duty change; led stays 0.
